// File: rtl/dff_arb_pkg.sv
// Shared constants for the dff_arbiter slice: FSM state encodings and
// default sizing for the shared register bank.
package dff_arb_pkg;

    // FSM state encodings
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    // Default sizing
    localparam int unsigned DEF_N_REQ    = 4;
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_LOCK_MAX = 15;

endpackage : dff_arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: finds the first asserted request at or
// after ptr_i, wrapping modulo N_REQ.
module rr_pick
    import dff_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned IDX_W = $clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] win_c_o,
    output logic             valid_c_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit to ptr wins
    always_comb begin
        cand      = '0;
        win_c_o   = '0;
        valid_c_o = 1'b0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % int'(N_REQ));
            if (req_i[cand]) begin
                valid_c_o = 1'b1;
                win_c_o   = cand;
            end
        end
    end

endmodule : rr_pick

// File: rtl/dff_arbiter.sv
// Round-robin arbiter sharing one enable/clear register bank between
// N_REQ requesters, with lock-based bursts and a synchronous clear.
// Optional build macro DFF_ARB_TIMEOUT_EN bounds LOCKED to LOCK_MAX cycles.
module dff_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = DEF_N_REQ,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned LOCK_MAX = DEF_LOCK_MAX
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       lock,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    input  logic                   sw_clr,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   dff_en,
    output logic [WIDTH-1:0]       dff_d,
    output logic                   dff_clr,
    output logic                   busy
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    // Elaboration-time guard on parameter ranges
    if (N_REQ < 2 || N_REQ > 8 || WIDTH < 1 || LOCK_MAX < 1) begin : g_param_check
        $error("dff_arbiter: parameter out of range");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q,   ptr_d;
    logic [IDX_W-1:0] win_q,   win_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic [N_REQ-1:0] ack_q,   ack_d;
    logic             en_q,    en_d;
    logic [WIDTH-1:0] dat_q,   dat_d;
    logic             clr_q,   clr_d;
    logic             busy_q,  busy_d;

    logic [IDX_W-1:0] pick_idx_c;
    logic             pick_valid_c;
    logic [N_REQ-1:0] pick_oh_c;
    logic [N_REQ-1:0] win_oh_c;
    logic [WIDTH-1:0] pick_dat_c;
    logic [WIDTH-1:0] win_dat_c;
    logic [IDX_W-1:0] nxt_ptr_c;
    logic             timeout_c;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_c_o   (pick_idx_c),
        .valid_c_o (pick_valid_c)
    );

    // One-hot and data selection for the fresh winner and the held winner
    always_comb begin
        pick_oh_c  = '0;
        win_oh_c   = '0;
        pick_dat_c = '0;
        win_dat_c  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_idx_c == IDX_W'(i)) begin
                pick_oh_c[i] = 1'b1;
                pick_dat_c   = wdata[i*WIDTH +: WIDTH];
            end
            if (win_q == IDX_W'(i)) begin
                win_oh_c[i] = 1'b1;
                win_dat_c   = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves one past the released winner, wrapping at N_REQ
    assign nxt_ptr_c = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);

`ifdef DFF_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // LOCKED residency counter, cleared on the GRANT->LOCKED transition
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_GRANT) begin
            cnt_d = '0;
        end else if (state_q == S_LOCKED) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter reaches LOCK_MAX at this edge: force release
    assign timeout_c = (state_q == S_LOCKED) && (cnt_q == CNT_W'(LOCK_MAX - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        en_d    = 1'b0;
        dat_d   = dat_q;
        clr_d   = 1'b0;

        if (sw_clr) begin
            state_d = S_IDLE;
            gnt_d   = '0;
            clr_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid_c) begin
                        state_d = S_GRANT;
                        win_d   = pick_idx_c;
                        gnt_d   = pick_oh_c;
                        ack_d   = pick_oh_c;
                        en_d    = 1'b1;
                        dat_d   = pick_dat_c;
                    end
                end
                S_GRANT: begin
                    if (lock[win_q]) begin
                        state_d = S_LOCKED;
                    end else begin
                        state_d = S_IDLE;
                        ptr_d   = nxt_ptr_c;
                        gnt_d   = '0;
                    end
                end
                S_LOCKED: begin
                    if (req[win_q]) begin
                        ack_d = win_oh_c;
                        en_d  = 1'b1;
                        dat_d = win_dat_c;
                    end
                    if (!lock[win_q] || timeout_c) begin
                        state_d = S_IDLE;
                        ptr_d   = nxt_ptr_c;
                        gnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            dat_q   <= '0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            dat_q   <= dat_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign dff_en  = en_q;
    assign dff_d   = dat_q;
    assign dff_clr = clr_q;
    assign busy    = busy_q;

endmodule : dff_arbiter

// File: tb/tb_dff_arbiter.sv
// Scoreboard bench for dff_arbiter: the driver pushes the expected bank
// transaction when it issues stimulus; the monitor pops and compares whenever
// the DUT presents dff_en, dff_clr or an ack.
module tb_dff_arbiter;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic        sw_clr;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        dff_en;
    logic [7:0]  dff_d;
    logic        dff_clr;
    logic        busy;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       en;
        logic [7:0] d;
        logic       clr;
        logic       busy;
    } exp_t;

    exp_t  sb_q[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    string phase  = "reset";

    dff_arbiter #(
        .N_REQ    (4),
        .WIDTH    (8),
        .LOCK_MAX (3)
    ) dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .req     (req),
        .lock    (lock),
        .wdata   (wdata),
        .sw_clr  (sw_clr),
        .gnt     (gnt),
        .ack     (ack),
        .dff_en  (dff_en),
        .dff_d   (dff_d),
        .dff_clr (dff_clr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic setw(input int i, input logic [7:0] v);
        wdata[i*8 +: 8] = v;
    endtask

    task automatic push_wr(input int idx, input logic [7:0] d, input bit gnt_on, input bit bsy);
        exp_t e;
        e.gnt  = gnt_on ? 4'(1 << idx) : 4'b0000;
        e.ack  = 4'(1 << idx);
        e.en   = 1'b1;
        e.d    = d;
        e.clr  = 1'b0;
        e.busy = bsy;
        sb_q.push_back(e);
    endtask

    task automatic push_clr();
        exp_t e;
        e      = '0;
        e.clr  = 1'b1;
        sb_q.push_back(e);
    endtask

    task automatic check_idle(input string nm, input bit with_d);
        chk({nm, "_gnt"},  32'(gnt),     32'h0);
        chk({nm, "_ack"},  32'(ack),     32'h0);
        chk({nm, "_en"},   32'(dff_en),  32'h0);
        chk({nm, "_clr"},  32'(dff_clr), 32'h0);
        chk({nm, "_busy"}, 32'(busy),    32'h0);
        if (with_d) chk({nm, "_d"}, 32'(dff_d), 32'h0);
    endtask

    // Monitor: compare every presented bank transaction against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (clr_n && (dff_en || dff_clr || (ack != 4'b0000))) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_event", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk("gnt",  32'(gnt),     32'(e.gnt));
                chk("ack",  32'(ack),     32'(e.ack));
                chk("en",   32'(dff_en),  32'(e.en));
                chk("clr",  32'(dff_clr), 32'(e.clr));
                chk("busy", 32'(busy),    32'(e.busy));
                if (e.en) chk("d", 32'(dff_d), 32'(e.d));
                chk("en_clr_excl", 32'(dff_en & dff_clr), 32'h0);
            end
        end
    end

    initial begin
        clr_n  = 1'b0;
        req    = '0;
        lock   = '0;
        wdata  = '0;
        sw_clr = 1'b0;

        // Reset and idle
        #1;
        check_idle("in_reset", 1'b1);
        #9 clr_n = 1'b1;
        phase = "idle";
        for (int i = 0; i < 5; i++) begin
            step();
            check_idle("idle", 1'b1);
        end

        // Single write from requester 2, then pointer lands on 3
        phase = "single";
        setw(2, 8'hA5);
        req = 4'b0100;
        push_wr(2, 8'hA5, 1'b1, 1'b1);
        step();
        req = 4'b0000;
        step();
        check_idle("single_release", 1'b0);
        setw(3, 8'h3C);
        req = 4'b1100;
        push_wr(3, 8'h3C, 1'b1, 1'b1);
        step();
        req = 4'b0000;
        step();

        // Round-robin fairness with all requesters held
        phase = "rr";
        for (int i = 0; i < 4; i++) setw(i, 8'(8'hD0 + i));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_wr(k % 4, 8'(8'hD0 + (k % 4)), 1'b1, 1'b1);
            step();
            step();
        end
        req = 4'b0000;
        step();

        // Locked burst by requester 1; requester 0 waits; final write on lock drop
        phase = "lock";
        setw(1, 8'hE0);
        setw(0, 8'h5A);
        req  = 4'b0011;
        lock = 4'b0011;
        push_wr(1, 8'hE0, 1'b1, 1'b1);
        step();
        step();
        for (int i = 1; i <= 3; i++) begin
            setw(1, 8'(i));
            push_wr(1, 8'(i), 1'b1, 1'b1);
            step();
        end
        setw(1, 8'h04);
        lock = 4'b0001;
        push_wr(1, 8'h04, 1'b0, 1'b0);
        step();
        req  = 4'b0001;
        lock = 4'b0000;
        push_wr(0, 8'h5A, 1'b1, 1'b1);
        step();
        req = 4'b0000;
        step();
        check_idle("lock_done", 1'b0);

        // sw_clr pre-empts a locked write; pointer unchanged afterwards
        phase = "swclr";
        setw(1, 8'h77);
        req  = 4'b0010;
        lock = 4'b0010;
        push_wr(1, 8'h77, 1'b1, 1'b1);
        step();
        step();
        sw_clr = 1'b1;
        req    = 4'b0011;
        setw(1, 8'h88);
        push_clr();
        step();
        sw_clr = 1'b0;
        lock   = 4'b0000;
        req    = 4'b0011;
        setw(1, 8'h99);
        push_wr(1, 8'h99, 1'b1, 1'b1);
        step();
        req = 4'b0000;
        step();
        // Held sw_clr beats a request in IDLE and keeps dff_clr high
        sw_clr = 1'b1;
        req    = 4'b0100;
        push_clr();
        step();
        push_clr();
        step();
        sw_clr = 1'b0;
        req    = 4'b0000;
        step();
        check_idle("swclr_done", 1'b0);

`ifdef DFF_ARB_TIMEOUT_EN
        // Requester 0 holds lock; forced release after LOCK_MAX locked cycles
        phase = "timeout";
        setw(0, 8'hC0);
        setw(1, 8'hC1);
        req  = 4'b0011;
        lock = 4'b0001;
        push_wr(0, 8'hC0, 1'b1, 1'b1);
        step();
        step();
        push_wr(0, 8'hC0, 1'b1, 1'b1);
        step();
        push_wr(0, 8'hC0, 1'b1, 1'b1);
        step();
        push_wr(0, 8'hC0, 1'b0, 1'b0);
        step();
        push_wr(1, 8'hC1, 1'b1, 1'b1);
        step();
        req  = 4'b0000;
        lock = 4'b0000;
        step();
        check_idle("timeout_done", 1'b0);
`endif

        // Asynchronous reset in LOCKED with a write pending: no ack, pointer reset
        phase = "areset";
        setw(2, 8'hAB);
        req  = 4'b0100;
        lock = 4'b0100;
        push_wr(2, 8'hAB, 1'b1, 1'b1);
        step();
        step();
        #2 clr_n = 1'b0;
        #1;
        check_idle("areset", 1'b1);
        step();
        clr_n = 1'b1;
        req   = 4'b0000;
        lock  = 4'b0000;
        step();
        check_idle("after_areset", 1'b1);
        setw(1, 8'h1B);
        req = 4'b1010;
        push_wr(1, 8'h1B, 1'b1, 1'b1);
        step();
        req = 4'b0000;
        step();
        step();

        phase = "end";
        chk("queue_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_dff_arbiter

// File: doc/dff_arbiter.md
Name: dff_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one WIDTH-bit enable/clear register bank (built from the lab dff cell: clk, clr, en, d, q) between N_REQ requesters.
- Picks one requester, drives the bank's en/d/clr for it, and acknowledges each write.
- A granted requester may hold the bank across consecutive writes with its lock line.
- Sits between requester logic and the shared dff bank, which is instantiated outside this block.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of the shared register bank
- LOCK_MAX, 15, maximum cycles in LOCKED; used only with DFF_ARB_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester write request, level
- lock  in  N_REQ  per-requester hold-grant request; meaningful only for the granted requester
- wdata  in  N_REQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH]
- sw_clr  in  1  synchronous clear request for the shared bank; highest priority
- gnt  out  N_REQ  one-hot grant, registered
- ack  out  N_REQ  one-hot, one-cycle pulse per completed write
- dff_en  out  1  enable to the shared bank
- dff_d  out  WIDTH  data to the shared bank
- dff_clr  out  1  synchronous clear to the shared bank
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (clr_n=0, asynchronous): state=IDLE, rr pointer=0, gnt=0, ack=0, dff_en=0, dff_d=0, dff_clr=0, busy=0. All outputs are registered.
- States are IDLE, GRANT, LOCKED.
- Round-robin search starts at index ptr and wraps modulo N_REQ. The first asserted req wins.
- IDLE:
  - If req≠0, latch the winner index w and wdata[w].
  - Next cycle: state=GRANT, gnt=onehot(w), dff_en=1, dff_d=latched data, ack[w]=1.
  - Latency is one cycle from sampled req to dff_en.
- GRANT, then at the next edge:
  - If lock[w]=1, go to LOCKED.
  - Otherwise go to IDLE, set ptr=(w+1) mod N_REQ, gnt=0.
  - dff_en drops unless re-driven by LOCKED.
- LOCKED:
  - Each cycle with req[w]=1 registers dff_en=1, dff_d=wdata[w], ack[w]=1 for the following cycle.
  - Cycles with req[w]=0 give dff_en=0, ack=0.
  - Other requesters are ignored.
  - When lock[w]=0: next state=IDLE, ptr=(w+1) mod N_REQ, gnt=0.
  - A final write coincident with lock dropping is still performed and acked.
- Back-to-back: a requester still asserting req after release can win again only after the others have been searched. A single active requester is re-granted after one IDLE cycle, giving 50% max throughput unless it uses lock.
- sw_clr=1 in any state:
  - Next cycle: dff_clr=1, dff_en=0, ack=0, gnt=0, state=IDLE; ptr unchanged.
  - Any pending write that cycle is dropped and not acked.
  - sw_clr beats any req/lock sampled in the same cycle.
- dff_clr is a one-cycle pulse per sw_clr cycle. A held sw_clr keeps dff_clr high.
- dff_en and dff_clr are never high together.
- Asynchronous reset mid-LOCKED aborts the transfer immediately; no ack.
- lock from a non-granted requester has no effect.

Optional Feature:
- Macro DFF_ARB_TIMEOUT_EN.
- Defined: a LOCKED cycle counter (width clog2(LOCK_MAX+1)) clears on entering LOCKED. When it reaches LOCK_MAX, the block forces the return to IDLE at the next edge and advances ptr, regardless of lock. Any write requested in that final cycle is still performed.
- Undefined: no counter; LOCKED lasts until lock[w] falls.

Decomposition:
- Shared package/include dff_arb_pkg:
  - state encoding localparams S_IDLE=2'd0, S_GRANT=2'd1, S_LOCKED=2'd2
  - default N_REQ and WIDTH constants
- One natural sub-module, rr_pick: combinational, inputs req and ptr, outputs winner index and valid.
- Everything else (FSM, pointer, output registers, timeout counter) lives in dff_arbiter.

Test Plan:
1. Reset, then idle: clr_n=0 for 10 ns, then 1 with req=0 → all outputs 0, busy=0 for 5 cycles.
2. Single write: req=4'b0100, wdata[2]=8'hA5, lock=0 for one cycle → next cycle gnt=4'b0100, dff_en=1, dff_d=8'hA5, ack=4'b0100; then idle; ptr=3.
3. Round-robin fairness: req=4'b1111 held, lock=0 → grants in order 0,1,2,3,0 on alternating cycles, each with a one-cycle ack.
4. Locked burst: requester 1 gets gnt, holds lock=1, req=1 with data 8'h01..8'h04 over 4 cycles → four dff_en pulses with matching dff_d; req[0]=1 is not granted until lock drops.
5. sw_clr pre-emption: in LOCKED, assert sw_clr for 1 cycle together with req → next cycle dff_clr=1, dff_en=0, ack=0, gnt=0, state=IDLE; ptr unchanged.
6. Timeout (DFF_ARB_TIMEOUT_EN, LOCK_MAX=3): requester 0 holds lock=1 → released after 3 LOCKED cycles; requester 1 (req=1) is granted next.
